// File: rtl/fmap_stream_tx.sv
// ---------------------------------------------------------------------------
// fmap_stream_tx
//
// Purpose:
//   Snapshots a flattened FP16 feature map (K channels x H rows x W columns)
//   on `start` and streams it out one word per beat on a valid/ready
//   interface. Each beat carries channel/row/column tags and a last flag.
//   Words go out in ascending flat index i = c*H*W + r*W + x, so the column
//   changes fastest. Data is passed through bit-exact.
//
// Ports:
//   clk      in   clock, rising-edge
//   reset    in   asynchronous active-high reset, clears all state
//   start    in   request to snapshot fmap_in and begin a transfer
//   fmap_in  in   SIZE*DATA_WIDTH flattened map, word i at [i*DW +: DW]
//   busy     out  transfer in progress
//   done     out  one-cycle pulse after the final handshake
//   m_valid  out  stream word valid
//   m_ready  in   consumer ready
//   m_data   out  current word
//   m_last   out  current word is index SIZE-1
//   m_chan   out  channel tag of current word
//   m_row    out  row tag of current word
//   m_col    out  column tag of current word
// ---------------------------------------------------------------------------
module fmap_stream_tx #(
    parameter  int DATA_WIDTH = 16,
    parameter  int K          = 2,
    parameter  int H          = 2,
    parameter  int W          = 2,
    localparam int SIZE       = K * H * W,
    localparam int CW         = (K > 1) ? $clog2(K) : 1,
    localparam int RW         = (H > 1) ? $clog2(H) : 1,
    localparam int XW         = (W > 1) ? $clog2(W) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [SIZE*DATA_WIDTH-1:0] fmap_in,
    output logic                       busy,
    output logic                       done,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_last,
    output logic [CW-1:0]              m_chan,
    output logic [RW-1:0]              m_row,
    output logic [XW-1:0]              m_col
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_WIDTH-1:0] r_shadow [SIZE];
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  r_done;
    logic [CW-1:0]         r_chan;
    logic [RW-1:0]         r_row;
    logic [XW-1:0]         r_col;

    logic                  w_start;
    logic                  w_hs;
    logic                  w_final;
    logic [IW-1:0]         w_idx_inc;

    // Only an idle block accepts start; a start during SEND is dropped.
    assign w_start   = (r_state == S_IDLE) && start;
    assign w_hs      = (r_state == S_SEND) && m_ready;
    assign w_final   = w_hs && r_last;
    assign w_idx_inc = r_idx + 1'b1;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)   w_state_next = S_SEND;
            S_SEND:  if (w_final) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Shadow copy of the map, taken only when a transfer is accepted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_start) begin
            for (int i = 0; i < SIZE; i++) begin
                r_shadow[i] <= fmap_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stream datapath. The output word and last flag are registered one step
    // ahead: on start word 0 comes straight from fmap_in (the shadow is being
    // written in the same edge), on each non-final handshake the next word is
    // fetched from the shadow. Nothing moves without a handshake, which keeps
    // data/tags/last stable under backpressure.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
            r_done <= 1'b0;
            r_chan <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else begin
            r_done <= w_final;
            if (w_start) begin
                r_idx  <= '0;
                r_data <= fmap_in[DATA_WIDTH-1:0];
                r_last <= (SIZE == 1);
                r_chan <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_hs) begin
                if (r_last) begin
                    r_last <= 1'b0;
                end else begin
                    r_idx  <= w_idx_inc;
                    r_data <= r_shadow[w_idx_inc];
                    r_last <= (w_idx_inc == IW'(SIZE - 1));
                    // Tags are independent wrapping counters: col -> row -> chan.
                    if (r_col == XW'(W - 1)) begin
                        r_col <= '0;
                        if (r_row == RW'(H - 1)) begin
                            r_row  <= '0;
                            r_chan <= r_chan + 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end
        end
    end

    assign busy    = (r_state == S_SEND);
    assign m_valid = (r_state == S_SEND);
    assign done    = r_done;
    assign m_data  = r_data;
    assign m_last  = r_last;
    assign m_chan  = r_chan;
    assign m_row   = r_row;
    assign m_col   = r_col;

endmodule

// File: tb/tb_fmap_stream_tx.sv
module tb_fmap_stream_tx;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // Default instance: K=2, H=2, W=2
    logic         start0 = 1'b0;
    logic [127:0] fmap0  = '0;
    logic         busy0, done0, valid0, last0;
    logic         ready0 = 1'b0;
    logic [15:0]  data0;
    logic [0:0]   chan0, row0, col0;

    fmap_stream_tx dut0 (
        .clk     (clk),
        .reset   (reset),
        .start   (start0),
        .fmap_in (fmap0),
        .busy    (busy0),
        .done    (done0),
        .m_valid (valid0),
        .m_ready (ready0),
        .m_data  (data0),
        .m_last  (last0),
        .m_chan  (chan0),
        .m_row   (row0),
        .m_col   (col0)
    );

    // Sweep instance: K=3, H=1, W=4
    logic         start1 = 1'b0;
    logic [191:0] fmap1  = '0;
    logic         busy1, done1, valid1, last1;
    logic         ready1 = 1'b0;
    logic [15:0]  data1;
    logic [1:0]   chan1;
    logic [0:0]   row1;
    logic [1:0]   col1;

    fmap_stream_tx #(.DATA_WIDTH(16), .K(3), .H(1), .W(4)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .start   (start1),
        .fmap_in (fmap1),
        .busy    (busy1),
        .done    (done1),
        .m_valid (valid1),
        .m_ready (ready1),
        .m_data  (data1),
        .m_last  (last1),
        .m_chan  (chan1),
        .m_row   (row1),
        .m_col   (col1)
    );

    typedef struct {
        logic [15:0] a_word;
        logic [15:0] b_word;
        logic        c;
        logic        r;
        logic        x;
        logic        last;
    } vec_t;

    vec_t         tab [8];
    logic [127:0] map_a;
    logic [127:0] map_b;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at the negedge where word 0 is presented. Returns at the negedge
    // of the done cycle. mode 0: ready always high; mode 1: ready 1,0,1,0...
    task automatic run0(input int mode, input bit use_b, input int inject_beat,
                        input bit overwrite, input int exp_cycles);
        int          beat     = 0;
        int          cyc      = 0;
        bit          stalled  = 0;
        bit          injected = 0;
        logic [15:0] sd;
        logic [3:0]  stag;
        logic [15:0] ew;
        while (beat < 8 && cyc < 60) begin
            chk("valid", 32'(valid0), 32'd1);
            chk("busy", 32'(busy0), 32'd1);
            chk("no_done_mid", 32'(done0), 32'd0);
            if (stalled) begin
                chk("stall_data", 32'(data0), 32'(sd));
                chk("stall_tags", 32'({chan0, row0, col0, last0}), 32'(stag));
            end
            start0 = 1'b0;
            if (overwrite) fmap0 = '1;
            if (beat == inject_beat && !injected) begin
                start0   = 1'b1;
                fmap0    = map_b;
                injected = 1;
            end
            ready0 = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (ready0) begin
                ew = use_b ? tab[beat].b_word : tab[beat].a_word;
                chk("data", 32'(data0), 32'(ew));
                chk("tags", 32'({chan0, row0, col0}), 32'({tab[beat].c, tab[beat].r, tab[beat].x}));
                chk("last", 32'(last0), 32'(tab[beat].last));
                $display("dut0 beat %0d data=%h c=%0d r=%0d x=%0d last=%0d", beat, data0, chan0, row0, col0, last0);
                beat++;
                stalled = 0;
            end else begin
                stalled = 1;
                sd      = data0;
                stag    = {chan0, row0, col0, last0};
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b0;
        chk("beats", 32'(beat), 32'd8);
        chk("cycles", 32'(cyc), 32'(exp_cycles));
        chk("done_pulse", 32'(done0), 32'd1);
        chk("busy_at_done", 32'(busy0), 32'd0);
        chk("valid_at_done", 32'(valid0), 32'd0);
    endtask

    task automatic start_a();
        fmap0  = map_a;
        start0 = 1'b1;
        ready0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tab[0] = '{16'h3C00, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[1] = '{16'h4000, 16'h0202, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[2] = '{16'h4200, 16'h0303, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[3] = '{16'h4400, 16'h0404, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[4] = '{16'h4500, 16'h0505, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[5] = '{16'h4600, 16'h0606, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[6] = '{16'h4700, 16'h0707, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[7] = '{16'h4800, 16'h0808, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            map_a[i*16 +: 16] = tab[i].a_word;
            map_b[i*16 +: 16] = tab[i].b_word;
        end

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        chk("rst_last", 32'(last0), 32'd0);
        chk("rst_tags", 32'({chan0, row0, col0}), 32'd0);
        chk("rst_valid1", 32'(valid1), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full-rate transfer
        start_a();
        run0(0, 0, -1, 0, 8);
        @(negedge clk);

        // Alternating backpressure: 15 cycles
        start_a();
        run0(1, 0, -1, 0, 15);
        @(negedge clk);

        // Snapshot integrity: fmap_in overwritten with 0xFFFF after start
        start_a();
        run0(0, 0, -1, 1, 8);
        @(negedge clk);

        // Start during busy ignored, then start in done cycle accepted
        start_a();
        run0(0, 0, 3, 0, 8);
        fmap0  = map_b;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        chk("done_cycle_start_valid", 32'(valid0), 32'd1);
        run0(0, 1, -1, 0, 8);
        @(negedge clk);

        // Reset while beat 5 is stalled
        start_a();
        for (int b = 0; b < 5; b++) begin
            ready0 = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_data", 32'(data0), 32'(tab[5].a_word));
        ready0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_stall", 32'(data0), 32'(tab[5].a_word));
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(valid0), 32'd0);
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_done", 32'(done0), 32'd0);
        chk("arst_data", 32'(data0), 32'd0);
        chk("arst_last", 32'(last0), 32'd0);
        chk("arst_tags", 32'({chan0, row0, col0}), 32'd0);
        $display("dut0 reset applied mid-transfer");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done0), 32'd0);
            chk("post_rst_idle", 32'(valid0), 32'd0);
        end
        start_a();
        run0(0, 0, -1, 0, 8);

        // Parameter sweep K=3 H=1 W=4 with random ready
        begin
            int          beat = 0;
            int          cyc  = 0;
            int          lows = 0;
            bit          stalled = 0;
            logic [15:0] sd;
            logic [5:0]  stag;
            logic [15:0] ew;
            for (int i = 0; i < 12; i++) fmap1[i*16 +: 16] = 16'hA000 + 16'(i * 16'h0111);
            @(negedge clk);
            start1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            while (beat < 12 && cyc < 400) begin
                chk("sw_valid", 32'(valid1), 32'd1);
                if (stalled) begin
                    chk("sw_stall_data", 32'(data1), 32'(sd));
                    chk("sw_stall_tags", 32'({chan1, row1, col1, last1}), 32'(stag));
                end
                ready1 = 1'($urandom_range(0, 1));
                if (ready1) begin
                    ew = 16'hA000 + 16'(beat * 16'h0111);
                    chk("sw_data", 32'(data1), 32'(ew));
                    chk("sw_chan", 32'(chan1), 32'(beat / 4));
                    chk("sw_row", 32'(row1), 32'd0);
                    chk("sw_col", 32'(col1), 32'(beat % 4));
                    chk("sw_last", 32'(last1), 32'(beat == 11));
                    $display("dut1 beat %0d data=%h c=%0d r=%0d x=%0d last=%0d", beat, data1, chan1, row1, col1, last1);
                    beat++;
                    stalled = 0;
                end else begin
                    lows++;
                    stalled = 1;
                    sd      = data1;
                    stag    = {chan1, row1, col1, last1};
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
            chk("sw_beats", 32'(beat), 32'd12);
            chk("sw_cycles", 32'(cyc), 32'(12 + lows));
            chk("sw_done", 32'(done1), 32'd1);
            chk("sw_busy_at_done", 32'(busy1), 32'd0);
            chk("sw_valid_at_done", 32'(valid1), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
